// File: rtl/one_hot_grant_decoder.sv
// Binary index to registered one-hot grant with ack release and a one-cycle gap.
// Optional grant hold timeout is enabled by defining DEC_TIMEOUT_EN.
module one_hot_grant_decoder #(
   parameter int unsigned N       = 8,
   parameter int unsigned M       = $clog2(N),
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] in_idx,
   output logic [N-1:0] grant,
   input  logic         ack,
   output logic         busy,
   output logic         err,
   output logic         timeout,
   output logic [7:0]   grant_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           err_q, err_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           idx_ok_c;
   logic           expire_c;

   // A zero hold limit would expire before the grant is ever seen.
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("one_hot_grant_decoder: TIMEOUT must be at least 1");
   end

   assign idx_ok_c = (32'(in_idx) < N);

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && ready_q) begin
               if (idx_ok_c) begin
                  state_d = S_GRANT;
                  grant_d = N'(1) << in_idx;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_GRANT: begin
            // ack takes priority over a simultaneous expiry
            if (ack) begin
               state_d = S_GAP;
               grant_d = '0;
               cnt_d   = cnt_q + 8'd1;
            end else if (expire_c) begin
               state_d = S_GAP;
               grant_d = '0;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef DEC_TIMEOUT_EN
   localparam int unsigned HW = $clog2(TIMEOUT + 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;

   // Hold counter: cycles already spent in GRANT, cleared on any exit.
   assign expire_c = (hold_q == HW'(TIMEOUT - 1));

   always_comb begin
      hold_d    = '0;
      timeout_d = 1'b0;
      if (state_q == S_GRANT) begin
         if (!ack && expire_c) begin
            timeout_d = 1'b1;
         end else if (!ack) begin
            hold_d = hold_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign expire_c = 1'b0;
   assign timeout  = 1'b0;
`endif

   assign in_ready  = ready_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign grant_cnt = cnt_q;

endmodule

// File: doc/one_hot_grant_decoder.md
ONE_HOT_GRANT_DECODER -- requirements
Module: one_hot_grant_decoder

Interface
REQ-001 Parameter N, default 8: number of grant lines.
REQ-002 Parameter M, default $clog2(N): index width.
REQ-003 Parameter TIMEOUT, default 16: grant hold limit in cycles; used only when DEC_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_idx is valid.
REQ-007 in_ready  output  1  block can accept an index.
REQ-008 in_idx  input  M  binary index to decode, e.g. an index produced by the team's priority encoder.
REQ-009 grant  output  N  registered one-hot grant; all zeros when idle.
REQ-010 ack  input  1  granted agent releases the grant.
REQ-011 busy  output  1  high in GRANT and GAP.
REQ-012 err  output  1  one-cycle pulse when an out-of-range index is rejected.
REQ-013 timeout  output  1  one-cycle pulse when a grant is withdrawn by timeout.
REQ-014 grant_cnt  output  8  count of grants completed by ack.

Function
REQ-015 States SHALL be IDLE, GRANT and GAP.
REQ-016 IDLE: in_ready=1, busy=0, grant=0.
REQ-017 Transfer SHALL occur on a clock edge where in_valid and in_ready are both 1.
REQ-018 Transfer with in_idx<N: grant SHALL be 1<<in_idx from the next cycle, and state SHALL be GRANT.
REQ-019 Transfer with in_idx>=N (possible when N is not a power of 2): err SHALL pulse for exactly one cycle, state SHALL stay IDLE, and grant SHALL stay 0.
REQ-020 GRANT: in_ready=0, busy=1, and grant SHALL hold its one-hot value unchanged.
REQ-021 ack=1 sampled in GRANT: the next cycle SHALL have grant=0, state=GAP and grant_cnt incremented by 1.
REQ-022 grant_cnt SHALL wrap from 255 to 0.
REQ-023 GAP SHALL last exactly one cycle with in_ready=0 and busy=1, then go to IDLE.
REQ-024 in_ready SHALL therefore reassert 2 cycles after ack is sampled.
REQ-025 ack in IDLE or GAP SHALL be ignored.
REQ-026 in_valid while in_ready=0 SHALL be ignored; no input is buffered.
REQ-027 grant SHALL never have more than one bit set.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, grant=0, err=0, timeout=0, grant_cnt=0, hold counter=0, busy=0, in_ready=0 while asserted.
REQ-029 Reset mid-GRANT SHALL drop grant at once; no ack is required afterwards.
REQ-030 in_ready SHALL be 1 on the first clock edge after rst_n deasserts.

Configuration
REQ-031 Macro DEC_TIMEOUT_EN: when defined, a hold counter SHALL count cycles spent in GRANT.
REQ-032 With DEC_TIMEOUT_EN, if TIMEOUT cycles of GRANT pass without ack, the next cycle SHALL have grant=0, state=GAP and timeout pulsed for one cycle, with grant_cnt unchanged.
REQ-033 With DEC_TIMEOUT_EN, if ack arrives in the same cycle as expiry, ack SHALL win: no timeout pulse, and grant_cnt is incremented.
REQ-034 Without DEC_TIMEOUT_EN, timeout SHALL be tied to 0, no counter SHALL exist, and GRANT SHALL be held indefinitely.

Verification
REQ-035 N=8, accept in_idx=5 -> grant=8'b0010_0000 one cycle later; ack -> grant=0 next cycle, in_ready=1 two cycles after ack, grant_cnt=1.
REQ-036 N=6, in_idx=7 with in_valid -> err pulses 1 cycle, grant stays 0, in_ready stays 1.
REQ-037 In GRANT, in_valid with in_idx=2 held for 10 cycles -> grant unchanged, index 2 not accepted.
REQ-038 rst_n low mid-GRANT -> grant=0 immediately; after release, in_ready=1 and grant_cnt=0.
REQ-039 256 accept/ack cycles -> grant_cnt wraps to 0.
REQ-040 DEC_TIMEOUT_EN, TIMEOUT=16, no ack -> grant cleared after 16 GRANT cycles with a 1-cycle timeout pulse; repeat with ack on the expiry cycle -> no timeout, grant_cnt increments.
